nes_joypad_reader: RTL and testbench

NES_JOYPAD_READER -- requirements
Module: nes_joypad_reader

---
 rtl/nes_joypad_reader.sv | 139 +++++++++++++
 tb/tb_nes_joypad_reader.sv | 408 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nes_joypad_reader.sv
// NES controller poller: latches the pad, clocks out 8 serial bits,
// and presents them as an active-high button bitmap once per frame.
module nes_joypad_reader #(
  parameter int POLL_CYC  = 833333,
  parameter int LATCH_CYC = 600,
  parameter int HALF_CYC  = 300
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       poll_en,
  input  logic       pad_data,
  output logic       pad_latch,
  output logic       pad_clk,
  output logic [7:0] buttons,
  output logic       valid
);

  localparam int M1 =
    (POLL_CYC > LATCH_CYC) ? POLL_CYC : LATCH_CYC;
  localparam int M2 =
    (M1 > HALF_CYC) ? M1 : HALF_CYC;
  localparam int CW = $clog2(M2 + 1);

  typedef logic [CW-1:0] cnt_t;

  localparam cnt_t POLL_END  = cnt_t'(POLL_CYC - 1);
  localparam cnt_t LATCH_END = cnt_t'(LATCH_CYC - 1);
  localparam cnt_t HALF_END  = cnt_t'(HALF_CYC - 1);

  typedef enum logic [2:0] {
    IDLE,
    LATCH,
    CLK_LO,
    CLK_HI,
    DONE
  } state_t;

  state_t      state_q, state_d;
  cnt_t        cnt_q, cnt_d;
  logic [2:0]  idx_q, idx_d;
  logic [7:0]  shift_q, shift_d;
  logic [7:0]  buttons_q, buttons_d;
  logic        valid_q, valid_d;
  logic        latch_q, latch_d;
  logic        pclk_q, pclk_d;
  logic        sync1_q, sync2_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= 1'b1;
      sync2_q <= 1'b1;
    end else begin
      sync1_q <= pad_data;
      sync2_q <= sync1_q;
    end
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + cnt_t'(1);
    idx_d     = idx_q;
    shift_d   = shift_q;
    buttons_d = buttons_q;
    unique case (state_q)
      IDLE: begin
        if (!poll_en) begin
          cnt_d = '0;
        end else if (cnt_q == POLL_END) begin
          state_d = LATCH;
          cnt_d   = '0;
        end
      end
      LATCH: begin
        if (cnt_q == LATCH_END) begin
          state_d = CLK_LO;
          cnt_d   = '0;
          idx_d   = '0;
        end
      end
      CLK_LO: begin
        if (cnt_q == HALF_END) begin
          shift_d[idx_q] = sync2_q;
          cnt_d          = '0;
          state_d = (idx_q == 3'd7) ? DONE : CLK_HI;
        end
      end
      CLK_HI: begin
        if (cnt_q == HALF_END) begin
          idx_d   = idx_q + 3'd1;
          cnt_d   = '0;
          state_d = CLK_LO;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
    // Outputs decode the next state so they toggle with it, glitch-free.
    if (state_d == DONE) begin
      buttons_d = ~shift_d;
    end
    valid_d = (state_d == DONE);
    latch_d = (state_d == LATCH);
    pclk_d  = (state_d == CLK_HI);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      shift_q   <= 8'hFF;
      buttons_q <= 8'h00;
      valid_q   <= 1'b0;
      latch_q   <= 1'b0;
      pclk_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      shift_q   <= shift_d;
      buttons_q <= buttons_d;
      valid_q   <= valid_d;
      latch_q   <= latch_d;
      pclk_q    <= pclk_d;
    end
  end

  assign pad_latch = latch_q;
  assign pad_clk   = pclk_q;
  assign buttons   = buttons_q;
  assign valid     = valid_q;

endmodule

// File: tb/tb_nes_joypad_reader.sv
// Bench for nes_joypad_reader: behavioural pad model, frame timing
// and waveform monitors, randomized button patterns.
module tb_nes_joypad_reader;

  localparam int POLL  = 16;
  localparam int LAT   = 4;
  localparam int HALF  = 4;
  localparam int FRAME = POLL + LAT + 15 * HALF + 1;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       poll_en = 1'b0;
  logic       pad_data;
  logic       pad_latch;
  logic       pad_clk;
  logic [7:0] buttons;
  logic       valid;

  nes_joypad_reader #(
    .POLL_CYC (POLL),
    .LATCH_CYC(LAT),
    .HALF_CYC (HALF)
  ) dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .poll_en  (poll_en),
    .pad_data (pad_data),
    .pad_latch(pad_latch),
    .pad_clk  (pad_clk),
    .buttons  (buttons),
    .valid    (valid)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;
  int cyc = 0;
  int last_valid = 0;

  // Pad model: 4021-style shift register, active-low, 1-filled.
  logic [7:0] pat = 8'h00;
  logic [1:0] mode = 2'd0;
  logic [7:0] sr = 8'hFF;

  always @(posedge pad_latch) sr = ~pat;
  always @(posedge pad_clk) sr = {1'b1, sr[7:1]};
  assign pad_data = (mode == 2'd0) ? sr[0] : (mode == 2'd1);

  always @(posedge clk) cyc <= cyc + 1;

  // Waveform monitor
  int lat_w[$];
  int clk_w[$];
  int lat_run = 0;
  int clk_run = 0;
  int overlap = 0;
  int glitch = 0;
  logic [7:0] prev_btn = 8'h00;

  always @(negedge clk) begin
    if (!reset_n) begin
      lat_run  = 0;
      clk_run  = 0;
      prev_btn = buttons;
    end else begin
      if (pad_latch) lat_run++;
      else if (lat_run != 0) begin
        lat_w.push_back(lat_run);
        lat_run = 0;
      end
      if (pad_clk) clk_run++;
      else if (clk_run != 0) begin
        clk_w.push_back(clk_run);
        clk_run = 0;
      end
      if (pad_latch && pad_clk) overlap++;
      if (!valid && buttons !== prev_btn) glitch++;
      prev_btn = buttons;
    end
  end

  task automatic wait_valid(output int t);
    bit ok;
    ok = 1'b0;
    t = 0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk);
      if (valid === 1'b1) begin
        ok = 1'b1;
        t = cyc;
        break;
      end
    end
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL wait_valid: no valid pulse in 400 cycles");
    end
  endtask

  task automatic wait_latch(output int n);
    n = 0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      n++;
      if (pad_latch === 1'b1) break;
    end
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    poll_en = 1'b1;
    mode = 2'd0;
    repeat (3) @(negedge clk);
    n_chk += 4;
    if (pad_latch !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_latch: got %b want 0", pad_latch);
    end
    if (pad_clk !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_clk: got %b want 0", pad_clk);
    end
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_valid: got %b want 0", valid);
    end
    if (buttons !== 8'h00) begin
      n_fail++;
      $display("FAIL reset_buttons: got %h want 00", buttons);
    end
  endtask

  task automatic test_first_frame;
    int n, t1, t2;
    pat = 8'h09;
    @(negedge clk);
    reset_n = 1'b1;
    wait_latch(n);
    n_chk++;
    if (n != POLL) begin
      n_fail++;
      $display("FAIL first_latch: got %0d want %0d", n, POLL);
    end
    wait_valid(t1);
    n_chk++;
    if (buttons !== 8'h09) begin
      n_fail++;
      $display("FAIL first_buttons: got %h want 09", buttons);
    end
    @(negedge clk);
    n_chk++;
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL valid_width: got %b want 0", valid);
    end
    wait_valid(t2);
    n_chk += 2;
    if (t2 - t1 != FRAME) begin
      n_fail++;
      $display("FAIL frame_len: got %0d want %0d", t2 - t1, FRAME);
    end
    if (buttons !== 8'h09) begin
      n_fail++;
      $display("FAIL second_buttons: got %h want 09", buttons);
    end
    last_valid = t2;
  endtask

  task automatic test_random_frames;
    int t;
    for (int k = 0; k < 6; k++) begin
      pat = 8'($urandom);
      wait_valid(t);
      n_chk += 2;
      if (buttons !== pat) begin
        n_fail++;
        $display("FAIL rand_buttons[%0d]: got %h want %h", k, buttons, pat);
      end
      if (t - last_valid != FRAME) begin
        n_fail++;
        $display("FAIL rand_period[%0d]: got %0d want %0d",
                 k, t - last_valid, FRAME);
      end
      last_valid = t;
    end
  endtask

  task automatic test_step;
    int t;
    pat = 8'h09;
    wait_valid(t);
    n_chk++;
    if (buttons !== 8'h09) begin
      n_fail++;
      $display("FAIL step_09: got %h want 09", buttons);
    end
    pat = 8'h80;
    wait_valid(t);
    n_chk += 2;
    if (buttons !== 8'h80) begin
      n_fail++;
      $display("FAIL step_80: got %h want 80", buttons);
    end
    if (glitch != 0) begin
      n_fail++;
      $display("FAIL step_glitch: got %0d changes outside valid want 0",
               glitch);
    end
    last_valid = t;
  endtask

  task automatic test_tied;
    int t;
    mode = 2'd1;
    wait_valid(t);
    n_chk += 2;
    if (buttons !== 8'h00) begin
      n_fail++;
      $display("FAIL tied_high: got %h want 00", buttons);
    end
    if (t - last_valid != FRAME) begin
      n_fail++;
      $display("FAIL tied_period: got %0d want %0d", t - last_valid, FRAME);
    end
    last_valid = t;
    mode = 2'd2;
    wait_valid(t);
    n_chk++;
    if (buttons !== 8'hFF) begin
      n_fail++;
      $display("FAIL tied_low: got %h want FF", buttons);
    end
    last_valid = t;
    mode = 2'd0;
  endtask

  task automatic test_waveform;
    int t, bad_l, bad_c;
    #1;
    lat_w.delete();
    clk_w.delete();
    overlap = 0;
    pat = 8'($urandom);
    repeat (3) wait_valid(t);
    last_valid = t;
    bad_l = 0;
    bad_c = 0;
    foreach (lat_w[i]) if (lat_w[i] != LAT) bad_l++;
    foreach (clk_w[i]) if (clk_w[i] != HALF) bad_c++;
    n_chk += 5;
    if (lat_w.size() != 3) begin
      n_fail++;
      $display("FAIL wave_latch_cnt: got %0d want 3", lat_w.size());
    end
    if (bad_l != 0) begin
      n_fail++;
      $display("FAIL wave_latch_width: got %0d bad want 0", bad_l);
    end
    if (clk_w.size() != 21) begin
      n_fail++;
      $display("FAIL wave_clk_cnt: got %0d want 21", clk_w.size());
    end
    if (bad_c != 0) begin
      n_fail++;
      $display("FAIL wave_clk_width: got %0d bad want 0", bad_c);
    end
    if (overlap != 0) begin
      n_fail++;
      $display("FAIL wave_overlap: got %0d want 0", overlap);
    end
  endtask

  task automatic test_poll_drop;
    int rises, seen, n, t;
    logic pc_prev;
    pat = 8'($urandom) | 8'h10;
    rises = 0;
    pc_prev = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (pad_clk && !pc_prev) rises++;
      pc_prev = pad_clk;
      if (rises == 4) break;
    end
    poll_en = 1'b0;
    n_chk++;
    if (rises != 4) begin
      n_fail++;
      $display("FAIL drop_rises: got %0d want 4", rises);
    end
    wait_valid(t);
    n_chk++;
    if (buttons !== pat) begin
      n_fail++;
      $display("FAIL drop_buttons: got %h want %h", buttons, pat);
    end
    seen = 0;
    repeat (3 * FRAME) begin
      @(negedge clk);
      if (pad_latch || valid) seen++;
    end
    n_chk++;
    if (seen != 0) begin
      n_fail++;
      $display("FAIL drop_idle: got %0d active cycles want 0", seen);
    end
    poll_en = 1'b1;
    wait_latch(n);
    n_chk++;
    if (n != POLL) begin
      n_fail++;
      $display("FAIL drop_resume: got %0d want %0d", n, POLL);
    end
    wait_valid(t);
    last_valid = t;
  endtask

  task automatic reset_at(input bit on_rise, input int edges);
    int cnt, n;
    logic pc_prev;
    cnt = 0;
    pc_prev = 1'b0;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (on_rise && pad_clk && !pc_prev) cnt++;
      if (!on_rise && !pad_clk && pc_prev) cnt++;
      pc_prev = pad_clk;
      if (cnt == edges) break;
    end
    #2 reset_n = 1'b0;
    #1;
    n_chk += 4;
    if (pad_clk !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_clk: got %b want 0", pad_clk);
    end
    if (pad_latch !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_latch: got %b want 0", pad_latch);
    end
    if (buttons !== 8'h00) begin
      n_fail++;
      $display("FAIL rst_mid_buttons: got %h want 00", buttons);
    end
    if (valid !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_mid_valid: got %b want 0", valid);
    end
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    wait_latch(n);
    n_chk++;
    if (n != POLL) begin
      n_fail++;
      $display("FAIL rst_restart: got %0d want %0d", n, POLL);
    end
  endtask

  task automatic test_reset_mid;
    int t;
    pat = 8'($urandom) | 8'h01;
    reset_at(1'b1, 3);
    wait_valid(t);
    n_chk++;
    if (buttons !== pat) begin
      n_fail++;
      $display("FAIL rst_hi_frame: got %h want %h", buttons, pat);
    end
    pat = 8'($urandom) | 8'h02;
    reset_at(1'b0, 5);
    wait_valid(t);
    n_chk++;
    if (buttons !== pat) begin
      n_fail++;
      $display("FAIL rst_lo_frame: got %h want %h", buttons, pat);
    end
    last_valid = t;
  endtask

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    test_reset();
    test_first_frame();
    test_random_frames();
    test_step();
    test_tied();
    test_waveform();
    test_poll_drop();
    test_reset_mid();
    n_chk++;
    if (glitch != 0) begin
      n_fail++;
      $display("FAIL buttons_stable: got %0d changes outside valid want 0",
               glitch);
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
